// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute path: operation codes used by both
// the ALU control decoder and alu_exec_unit, plus the execute FSM encoding.
package alu_pkg;

    // Operation codes produced by the ALU control decoder.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0101;

    // Execute-unit states. SHIFT is only reachable when shifts are compiled in.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } alu_state_e;

    // True for the two iterative shift codes.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter for alu_exec_unit. Holds the operand
// accumulator, the remaining-shift down-counter and the shift direction.
// Only instantiated when ALU_SHIFT_EN is defined.
module alu_shift_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,    // capture operand, amount, direction
    input  logic               left_i,    // 1 = SLL, 0 = SRL (logical)
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] amount_i,
    output logic               busy_o,    // shifts still outstanding
    output logic               last_o,    // the next edge performs the final shift
    output logic [WIDTH-1:0]   acc_o,     // current accumulator value
    output logic [WIDTH-1:0]   next_o     // accumulator after one more shift
);

    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               left_q, left_d;

    assign busy_o = (cnt_q != '0);
    assign last_o = (cnt_q == SHAMT_W'(1));
    assign acc_o  = acc_q;
    assign next_o = left_q ? (acc_q << 1) : (acc_q >> 1);

    // Next state: load a new job, or shift once and count down while busy.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        left_d = left_q;
        if (load_i) begin
            acc_d  = data_i;
            cnt_d  = amount_i;
            left_d = left_i;
        end else if (busy_o) begin
            acc_d = next_o;
            cnt_d = cnt_q - SHAMT_W'(1);
        end
    end

    // State registers; reset clears the counter so an aborted shift stops.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            left_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            left_q <= left_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit with valid/ready request and result handshakes.
// Result, zero and error flags are registered together and held in DONE until
// the consumer takes them.
// Build option: define ALU_SHIFT_EN to support SLL/SRL through the iterative
// shifter; otherwise those codes are reported as unsupported.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

`ifdef ALU_SHIFT_EN
    logic [SHAMT_W-1:0] shamt;
    logic               shift_load;
    logic               shift_left;
    logic               shift_busy;
    logic               shift_last;
    logic [WIDTH-1:0]   shift_acc;
    logic [WIDTH-1:0]   shift_next;

    assign shamt = op_b[SHAMT_W-1:0];

    alu_shift_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load_i   (shift_load),
        .left_i   (shift_left),
        .data_i   (op_a),
        .amount_i (shamt),
        .busy_o   (shift_busy),
        .last_o   (shift_last),
        .acc_o    (shift_acc),
        .next_o   (shift_next)
    );
`endif

    assign result = result_q;
    assign zero   = zero_q;
    assign err    = err_q;

    // FSM next state, handshake outputs and the result to be registered.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef ALU_SHIFT_EN
        shift_load = 1'b0;
        shift_left = (operation == ALU_SLL);
`endif
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_DONE;
                    err_d   = 1'b0;
                    case (operation)
                        ALU_AND: result_d = op_a & op_b;
                        ALU_OR:  result_d = op_a | op_b;
                        ALU_ADD: result_d = op_a + op_b;
                        ALU_SUB: result_d = op_a - op_b;
`ifdef ALU_SHIFT_EN
                        ALU_SLL, ALU_SRL: begin
                            if (shamt == '0) begin
                                result_d = op_a;
                            end else begin
                                shift_load = is_shift_op(operation);
                                state_d    = ST_SHIFT;
                            end
                        end
`endif
                        // Unknown codes (including X/Z) report an error with a zero result.
                        default: begin
                            result_d = '0;
                            err_d    = 1'b1;
                        end
                    endcase
                end
            end
`ifdef ALU_SHIFT_EN
            ST_SHIFT: begin
                if (!shift_busy) begin
                    // Counter already exhausted: the accumulator is final.
                    result_d = shift_acc;
                    state_d  = ST_DONE;
                end else if (shift_last) begin
                    result_d = shift_next;
                    state_d  = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // result_q and zero_q are kept consistent, so the flag always tracks the registered result.
        zero_d = (result_d == '0);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute unit that consumes the 4-bit `operation` code produced by the ALU control decoder and performs the arithmetic/logic operation on two operands. It sits in the CPU execute stage between the decoder/register-file outputs and the write-back path. Every operation is issued through a valid/ready handshake, so multi-cycle operations can stall the pipeline. The result is returned through a second valid/ready handshake with a registered result, a zero flag and an error flag.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.
- `SHAMT_W`, 5: shift-amount width; must equal log2(`WIDTH`).

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: an operation request is presented.
- `in_ready` output 1: the unit can accept a request.
- `operation` input 4: operation code from the ALU control decoder.
- `op_a` input `WIDTH`: first operand.
- `op_b` input `WIDTH`: second operand; for shifts, `op_b[SHAMT_W-1:0]` is the shift amount.
- `out_valid` output 1: the result is available.
- `out_ready` input 1: the consumer accepts the result.
- `result` output `WIDTH`: registered result.
- `zero` output 1: high when `result` is 0.
- `err` output 1: the accepted `operation` code was not supported.

## Operation
Supported operation codes:
- 0000: AND.
- 0001: OR.
- 0010: ADD (wraps modulo 2^`WIDTH`; carry is discarded).
- 0110: SUB (`op_a - op_b`, two's complement, wraps).
- 0011: SLL, only when shifts are compiled in.
- 0101: SRL, logical, only when shifts are compiled in.
- Any other code: `result` = 0, `zero` = 1, `err` = 1. The 4'bz value is also treated as an unsupported code.

State machine, states IDLE, SHIFT and DONE:
- IDLE: `in_ready` = 1. A request is accepted when `in_valid` and `in_ready` are both high.
  - Non-shift code: compute the result, register it, go to DONE.
  - Shift code: latch `op_a` into an accumulator and the shift amount into a down-counter.
    - Count 0: go straight to DONE.
    - Count nonzero: go to SHIFT.
- SHIFT: each cycle, shift the accumulator 1 bit and decrement the counter. When the counter reaches 1, write the final value and go to DONE.
- DONE: `out_valid` = 1. `result`, `zero` and `err` are held stable while `out_ready` is low. When `out_ready` is high, go to IDLE.
- `in_ready` is low in SHIFT and DONE. Requests presented then are not accepted and must be held by the producer.
- `operation`, `op_a` and `op_b` are sampled only on the accept cycle. Later changes have no effect.

## Timing
- Reset values: state = IDLE, `in_ready` = 1, `out_valid` = 0, `result` = 0, `zero` = 1, `err` = 0.
- Reset asserted in any state, mid-shift included, aborts the operation with no output produced. Reset values appear the cycle after the reset edge.
- Non-shift latency: accepted at edge t, `out_valid` high from edge t+1.
- Shift latency: accepted at edge t, `out_valid` high from edge t+1+N, where N = shift amount (0..31).
- Throughput: at most one operation every 2 cycles. A new request can be accepted at the earliest on the cycle after the result handshake.
- `zero` and `err` are registered together with `result`. They are never combinational from the inputs.

## Configuration
- `ALU_SHIFT_EN` defined: SLL and SRL are supported, and the SHIFT state and shifter are present.
- `ALU_SHIFT_EN` undefined: codes 0011 and 0101 are unsupported (`err` = 1, `result` = 0). The SHIFT state is not built, and all latencies are 1 cycle.

## Structure
- Shared package `alu_pkg` holds:
  - operation-code constants: `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLL`, `ALU_SRL`;
  - the state encoding: IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10.
- The ALU control decoder imports the same package, so the code values exist in one place only.
- One sub-module, `alu_shift_iter`, holds the accumulator, the down-counter and the direction control. It exposes `load`, `busy` and `last` signals. It is instantiated only under `ALU_SHIFT_EN`.

## Test plan
- Reset, then ADD `op_a`=7, `op_b`=5 with `out_ready`=1: `result`=12, `zero`=0, `err`=0, `out_valid` one cycle after accept.
- SUB 0x10 − 0x10 gives `result`=0, `zero`=1. SUB 0 − 1 gives `result`=0xFFFFFFFF. AND 0xF0F0 & 0xFF00 gives 0xF000. OR gives 0xFFF0.
- SLL `op_a`=1, `op_b`=4 (macro on): `out_valid` at accept+5, `result`=0x10. SRL by 0 gives `result`=`op_a` at accept+1.
- Code 1111, and code 0011 with the macro off: `result`=0, `zero`=1, `err`=1.
- Hold `out_ready`=0 for 3 cycles in DONE while `in_valid`=1: `result` is stable, `in_ready`=0, and no second accept happens until the cycle after the handshake.
- Assert `rst` during a 20-bit SLL: next cycle state = IDLE, `out_valid`=0, `result`=0, and no output appears.
